// File: rtl/ram_zeroizing_be_pkg.sv
// Shared RAM definitions: zeroization state encoding and size derivations.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_zeroizing_be_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ZERO = 1'b1
   } zstate_e;

   function automatic int num_words(input int addr_bits);
      return 1 << addr_bits;
   endfunction

   function automatic int num_lanes(input int n, input int lane);
      return n / lane;
   endfunction

endpackage

// File: rtl/ram_zeroize_ctrl.sv
// Zeroization sequencer: sweeps every word address once after reset or on request.
// Latency: sweep occupies exactly 2**ADDR_BITS cycles; busy drops the cycle after the last word.
// Backpressure: while busy (or while a request is being taken) user commands must be dropped via cmd_en.
module ram_zeroize_ctrl
   import ram_zeroizing_be_pkg::*;
#(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 zero_req,
   output logic                 busy,
   output logic                 cmd_en,
   output logic                 zero_we,
   output logic [ADDR_BITS-1:0] zero_addr
);

   zstate_e              state, state_nxt;
   logic [ADDR_BITS-1:0] ptr, ptr_nxt;

   // State and sweep pointer; reset always restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ZERO;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next state: advance the sweep, leave after the top word, start on request when idle.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         ST_ZERO: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == {ADDR_BITS{1'b1}}) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (zero_req) begin
               state_nxt = ST_ZERO;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_ZERO;
            ptr_nxt   = '0;
         end
      endcase
   end

   assign busy      = (state == ST_ZERO);
   // A request taken this cycle wins over any read/write presented alongside it.
   assign cmd_en    = (state == ST_IDLE) && !zero_req;
   assign zero_we   = busy;
   assign zero_addr = ptr;

endmodule

// File: rtl/ram_zeroizing_be.sv
// Single-port word RAM with byte-lane writes, registered read port and hardware zeroization.
// Latency: read data one cycle after rd_en (read-first on same-address write); snapshot lags array by one cycle.
// Backpressure: none; wr_en/rd_en are silently dropped while busy or when zero_req is asserted.
module ram_zeroizing_be
   import ram_zeroizing_be_pkg::*;
#(
   parameter int N         = 64,
   parameter int ADDR_BITS = 4,
   parameter int LANE      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_BITS-1:0]          addr,
   input  logic [N-1:0]                  data_in,
   input  logic                          wr_en,
   input  logic [N/LANE-1:0]             be,
   input  logic                          rd_en,
   input  logic                          zero_req,
   output logic [N-1:0]                  data_out,
   output logic                          rd_valid,
   output logic                          busy,
   output logic [(2**ADDR_BITS)*N-1:0]   ram_flat
);

   localparam int NUM_WORDS = num_words(ADDR_BITS);
   localparam int NUM_LANES = num_lanes(N, LANE);

   logic [N-1:0]           ram [NUM_WORDS];
   logic [N-1:0]           wr_word;
   logic [NUM_WORDS*N-1:0] flat_nxt;
   logic                   cmd_en;
   logic                   zero_we;
   logic [ADDR_BITS-1:0]   zero_addr;

   ram_zeroize_ctrl #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .zero_req  (zero_req),
      .busy      (busy),
      .cmd_en    (cmd_en),
      .zero_we   (zero_we),
      .zero_addr (zero_addr)
   );

   // Lane merge: enabled lanes take new data, the rest keep the stored word.
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign wr_word[k*LANE +: LANE] = be[k] ? data_in[k*LANE +: LANE]
                                             : ram[addr][k*LANE +: LANE];
   end

   // Array update: sweep writes zeros, otherwise accepted user writes; reset leaves contents alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (zero_we) begin
            ram[zero_addr] <= '0;
         end else if (cmd_en && wr_en) begin
            ram[addr] <= wr_word;
         end
      end
   end

   // Read register: samples the pre-write word, so a same-address write is read-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= cmd_en && rd_en;
         if (cmd_en && rd_en) begin
            data_out <= ram[addr];
         end
      end
   end

   for (genvar i = 0; i < NUM_WORDS; i++) begin : g_flat
      assign flat_nxt[i*N +: N] = ram[i];
   end

   // Snapshot: full registered copy of the array, one cycle behind it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_flat <= '0;
      end else begin
         ram_flat <= flat_nxt;
      end
   end

endmodule

// File: tb/tb_ram_zeroizing_be.sv
// Scoreboard bench for ram_zeroizing_be: directed scenarios plus random traffic against a word-array model.
// Latency: expectations are queued at stimulus time and checked just after each clock edge.
// Backpressure: n/a.
module tb_ram_zeroizing_be;

   localparam int N    = 64;
   localparam int AB   = 4;
   localparam int LANE = 8;
   localparam int NW   = 16;
   localparam int NL   = 8;
   localparam int FW   = NW * N;

   logic          clk = 1'b0;
   logic          rst, wr_en, rd_en, zero_req;
   logic [AB-1:0] addr;
   logic [N-1:0]  data_in;
   logic [NL-1:0] be;
   logic [N-1:0]  data_out;
   logic          rd_valid, busy;
   logic [FW-1:0] ram_flat;

   always #5 clk = ~clk;

   ram_zeroizing_be #(.N(N), .ADDR_BITS(AB), .LANE(LANE)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .data_in  (data_in),
      .wr_en    (wr_en),
      .be       (be),
      .rd_en    (rd_en),
      .zero_req (zero_req),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy),
      .ram_flat (ram_flat)
   );

   typedef struct {
      logic          busy;
      logic          rv;
      logic [N-1:0]  dout;
      logic [FW-1:0] flat;
      logic [FW-1:0] mask;
   } exp_t;

   exp_t exp_q[$];
   exp_t me;

   int total = 0;
   int bad   = 0;

   // Reference model: plain word array, count of sweep cycles remaining, last read result.
   logic [N-1:0] m_mem [NW];
   bit           m_known [NW];
   int           m_zero_left = 0;
   logic [N-1:0] m_dout = '0;
   logic         m_rv = 1'b0;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_flat(input logic [FW-1:0] act, input logic [FW-1:0] exp, input logic [FW-1:0] mask);
      int first = -1;
      total++;
      for (int i = 0; i < NW; i++) begin
         if (first < 0 && ((act[i*N +: N] & mask[i*N +: N]) !== (exp[i*N +: N] & mask[i*N +: N])))
            first = i;
      end
      if (first >= 0) begin
         bad++;
         $display("FAIL ram_flat word %0d: got %h expected %h at %0t",
                  first, act[first*N +: N], exp[first*N +: N], $time);
      end
   endtask

   // Apply one cycle of stimulus and queue what the outputs must be after the next edge.
   task automatic step(input logic r, input logic w, input logic rd, input logic z,
                       input logic [AB-1:0] a, input logic [N-1:0] d, input logic [NL-1:0] b);
      exp_t e;
      @(negedge clk);
      rst = r; wr_en = w; rd_en = rd; zero_req = z; addr = a; data_in = d; be = b;
      for (int i = 0; i < NW; i++) begin
         e.flat[i*N +: N] = m_mem[i];
         e.mask[i*N +: N] = m_known[i] ? {N{1'b1}} : {N{1'b0}};
      end
      if (r) begin
         m_zero_left = NW;
         m_dout      = '0;
         m_rv        = 1'b0;
         e.flat      = '0;
         e.mask      = '1;
      end else if (m_zero_left > 0) begin
         m_mem[NW - m_zero_left]   = '0;
         m_known[NW - m_zero_left] = 1'b1;
         m_zero_left--;
         m_rv = 1'b0;
      end else if (z) begin
         m_zero_left = NW;
         m_rv        = 1'b0;
      end else begin
         m_rv = rd;
         if (rd) m_dout = m_mem[a];
         if (w) begin
            for (int k = 0; k < NL; k++)
               if (b[k]) m_mem[a][k*LANE +: LANE] = d[k*LANE +: LANE];
         end
      end
      e.busy = (m_zero_left > 0);
      e.rv   = m_rv;
      e.dout = m_dout;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Count consecutive busy cycles starting right after the edge just driven.
   task automatic count_busy(input string nm, input logic rd_during);
      int n = 0;
      @(posedge clk); #2;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step(1'b0, 1'b0, rd_during, 1'b0, AB'($urandom_range(0, NW-1)), '0, '0);
         @(posedge clk); #2;
      end
      chk(nm, 64'(n), 64'(NW));
   endtask

   task automatic read_all();
      for (int i = 0; i < NW; i++) step(1'b0, 1'b0, 1'b1, 1'b0, AB'(i), '0, '0);
      idle();
   endtask

   // Monitor: pop one expectation per edge and compare every observed output.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         chk("busy", 64'(busy), 64'(me.busy));
         chk("rd_valid", 64'(rd_valid), 64'(me.rv));
         chk("data_out", data_out, me.dout);
         chk_flat(ram_flat, me.flat, me.mask);
      end
   end

   initial begin
      logic [N-1:0] rnd;
      int t;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; zero_req = 1'b0;
      addr = '0; data_in = '0; be = '0;

      // Power-up sweep and all-zero contents.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      count_busy("reset_sweep_len", 1'b0);
      read_all();

      // Full write then low-half lane write.
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 64'h1111_1111_1111_1111, 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, '0, '0);
      @(posedge clk); #2;
      chk("lane_merge_data", data_out, 64'h0123_4567_FFFF_FFFF);
      chk("lane_merge_valid", 64'(rd_valid), 64'd1);

      // Read-first on same-address read/write.
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
      @(posedge clk); #2;
      chk("read_first_old", data_out, 64'hA5A5_A5A5_A5A5_A5A5);
      idle();
      @(posedge clk); #2;
      chk("flat_new_word", ram_flat[5*N +: N], 64'h5A5A_5A5A_5A5A_5A5A);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, '0, '0);
      @(posedge clk); #2;
      chk("read_after_write", data_out, 64'h5A5A_5A5A_5A5A_5A5A);

      // Fill, then zero_req together with a write; reads during the sweep are dropped.
      for (int i = 0; i < NW; i++) begin
         rnd = {$urandom, $urandom} | 64'h1;
         step(1'b0, 1'b1, 1'b0, 1'b0, AB'(i), rnd, 8'hFF);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      count_busy("zero_req_sweep_len", 1'b1);
      read_all();

      // Reset in the middle of a sweep restarts it.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (7) idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      count_busy("restart_sweep_len", 1'b0);

      // Random traffic.
      for (int c = 0; c < 10000; c++) begin
         step(($urandom % 1000) == 0, 1'($urandom), 1'($urandom), ($urandom % 150) == 0,
              AB'($urandom), {$urandom, $urandom}, NL'($urandom));
      end
      idle();

      t = 0;
      while (exp_q.size() > 0 && t < 10) begin
         @(posedge clk); #2;
         t++;
      end
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
